// File: rtl/fire_conv_pkg.sv
// Shared types and helpers for the parametrised fire expand convolution engine.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: engine state enum, default TAPS count, tap-count helper, ReLU/saturating requantiser.
package fire_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int KERNEL_DIM_DEF = 3;
  localparam int CHIN_DEF       = 16;
  localparam int TAPS           = KERNEL_DIM_DEF * KERNEL_DIM_DEF * CHIN_DEF;

  // Widest accumulator the requantiser can take.
  localparam int SAT_MAXW = 64;

  function automatic int calc_taps(input int kernel_dim, input int chin);
    return kernel_dim * kernel_dim * chin;
  endfunction

  // s carries 2*frac fractional bits (sign-extended to SAT_MAXW). Negative
  // sums clamp to zero; magnitudes above the largest positive output clamp to
  // 2^(width-1)-1; otherwise the result equals s[frac+width-1:frac]. The
  // caller truncates the return value to width bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_relu(
    input logic signed [SAT_MAXW-1:0] s,
    input int                         width,
    input int                         frac
  );
    logic signed [SAT_MAXW-1:0] sh;
    logic signed [SAT_MAXW-1:0] maxv;
    sh   = s >>> frac;
    maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (s < 0)         return '0;
    else if (sh > maxv) return maxv;
    else               return sh;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One MAC lane: registers pixel/weight (stage 1), multiplies and accumulates.
// Latency: beat in -> updated accumulator visible on acc_d_o one cycle later.
// Backpressure: load_i low freezes stage 1; acc_en_i low holds the accumulator.
// Ports: clk/rst, load_i (accepted beat), acc_en_i (stage 1 holds a beat),
//        first_i (stage 1 beat is tap 0), pix_i/wgt_i, acc_d_o (next accumulator value).
module conv_mac_lane #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        acc_en_i,
  input  logic                        first_i,
  input  logic signed [WIDTH-1:0]     pix_i,
  input  logic signed [WIDTH-1:0]     wgt_i,
  output logic signed [ACC_WIDTH-1:0] acc_d_o
);

  logic signed [WIDTH-1:0]     pix_q, wgt_q;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  assign prod     = pix_q * wgt_q;
  assign prod_ext = ACC_WIDTH'(prod);

  // Tap 0 overwrites the accumulator, so consecutive pixels need no clear bubble.
  always_comb begin
    acc_d = acc_q;
    if (acc_en_i) begin
      acc_d = first_i ? prod_ext : acc_q + prod_ext;
    end
  end

  // The output stage samples the next-state value so a pixel's result is
  // registered on the same edge as its last accumulation.
  assign acc_d_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      wgt_q <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) begin
        pix_q <= pix_i;
        wgt_q <= wgt_i;
      end
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fire_expand_conv_engine.sv
// Expand conv engine: DSP_NO MAC lanes over a streamed IFM, bias + ReLU + saturating requant.
// Latency: last tap of a pixel accepted at cycle c -> ofm_valid_o at c+2.
// Backpressure: ifm_valid_i low stalls tap counter, weight address and lane input stage.
// Ports: start_i/layer_sel_i begin a run; ifm_i/ifm_valid_i pixel beats; weight_addr_o/layer_o
//        address the weight ROM returning kernels_i; bias_i per lane; ofm_o/ofm_valid_o results;
//        busy_o while running, done_o one-cycle completion pulse.
module fire_expand_conv_engine
  import fire_conv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 14,
  parameter int DSP_NO     = 64,
  parameter int CHIN       = 16,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 64,
  parameter int NUM_LAYERS = 2,
  localparam int TAPS_N    = calc_taps(KERNEL_DIM, CHIN),
  localparam int AW        = $clog2(TAPS_N),
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [LW-1:0]                 layer_sel_i,
  input  logic [WIDTH-1:0]              ifm_i,
  input  logic                          ifm_valid_i,
  output logic [AW-1:0]                 weight_addr_o,
  output logic [LW-1:0]                 layer_o,
  input  logic [DSP_NO*WIDTH-1:0]       kernels_i,
  input  logic [DSP_NO*ACC_WIDTH-1:0]   bias_i,
  output logic [DSP_NO*WIDTH-1:0]       ofm_o,
  output logic                          ofm_valid_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int NPIX = WOUT * WOUT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_e          state_q, state_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [AW-1:0]   tap_q, tap_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            beat, last_tap;
  logic            s1_vld_q, s1_first_q, s1_last_q;
  logic [DSP_NO*WIDTH-1:0] ofm_q, ofm_d;
  logic            ofm_vld_q;

  assign beat     = (state_q == RUN) && ifm_valid_i;
  assign last_tap = (tap_q == AW'(TAPS_N - 1));

  // pix_q counts pixels whose last tap has been accepted; it decides the
  // RUN -> DRAIN transition, while DRAIN waits for the final result strobe.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    tap_d   = tap_q;
    pix_d   = pix_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          layer_d = layer_sel_i;
          tap_d   = '0;
          pix_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat) begin
          tap_d = last_tap ? '0 : tap_q + AW'(1);
          if (last_tap) begin
            pix_d = pix_q + PW'(1);
            if (pix_q == PW'(NPIX - 1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stage 1 still holding the final last-tap means the strobe seen now
        // belongs to an earlier pixel.
        if (ofm_vld_q && !(s1_vld_q && s1_last_q)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      tap_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      tap_q   <= tap_d;
      pix_q   <= pix_d;
    end
  end

  // Stage 1 control flags travel alongside the lane input registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_vld_q <= beat;
      if (beat) begin
        s1_first_q <= (tap_q == '0);
        s1_last_q  <= last_tap;
      end
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic signed [ACC_WIDTH-1:0] sum;

    conv_mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_i   (beat),
      .acc_en_i (s1_vld_q),
      .first_i  (s1_first_q),
      .pix_i    (ifm_i),
      .wgt_i    (kernels_i[g*WIDTH +: WIDTH]),
      .acc_d_o  (acc_nxt)
    );

    assign sum = acc_nxt + $signed(bias_i[g*ACC_WIDTH +: ACC_WIDTH]);
    assign ofm_d[g*WIDTH +: WIDTH] =
      WIDTH'(sat_relu(SAT_MAXW'(sum), WIDTH, FRAC_BITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ofm_q     <= '0;
      ofm_vld_q <= 1'b0;
    end else begin
      ofm_vld_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q && s1_last_q) ofm_q <= ofm_d;
    end
  end

  assign weight_addr_o = tap_q;
  assign layer_o       = layer_q;
  assign ofm_o         = ofm_q;
  assign ofm_valid_o   = ofm_vld_q;
  assign busy_o        = (state_q == RUN) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_fire_expand_conv_engine.sv
// Directed bench for fire_expand_conv_engine in a small configuration (4 lanes, 18 taps, 4 pixels).
module tb_fire_expand_conv_engine;

  localparam int WIDTH = 16, ACC_WIDTH = 32, FRAC_BITS = 14;
  localparam int DSP_NO = 4, CHIN = 2, KERNEL_DIM = 3, WOUT = 2, NUM_LAYERS = 2;
  localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int NPIX = WOUT * WOUT;
  localparam int AW = $clog2(TAPS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst = 1'b1;
  logic                        start_i = 1'b0;
  logic [0:0]                  layer_sel_i = '0;
  logic [WIDTH-1:0]            ifm_i = '0;
  logic                        ifm_valid_i = 1'b0;
  logic [AW-1:0]               weight_addr_o;
  logic [0:0]                  layer_o;
  logic [DSP_NO*WIDTH-1:0]     kernels_i;
  logic [DSP_NO*ACC_WIDTH-1:0] bias_i;
  logic [DSP_NO*WIDTH-1:0]     ofm_o;
  logic                        ofm_valid_o, busy_o, done_o;

  logic signed [WIDTH-1:0]     k_l0 [DSP_NO];
  logic signed [WIDTH-1:0]     k_l1 [DSP_NO];
  logic signed [ACC_WIDTH-1:0] b_v  [DSP_NO];

  int errors = 0;
  int checks = 0;

  // Weight ROM model: same kernel for every tap of a lane, selected by layer.
  always_comb begin
    kernels_i = '0;
    bias_i    = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      kernels_i[i*WIDTH +: WIDTH]       = layer_o ? k_l1[i] : k_l0[i];
      bias_i[i*ACC_WIDTH +: ACC_WIDTH]  = b_v[i];
    end
  end

  fire_expand_conv_engine #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS), .DSP_NO(DSP_NO),
    .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM), .WOUT(WOUT), .NUM_LAYERS(NUM_LAYERS)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .layer_sel_i(layer_sel_i),
    .ifm_i(ifm_i), .ifm_valid_i(ifm_valid_i), .weight_addr_o(weight_addr_o),
    .layer_o(layer_o), .kernels_i(kernels_i), .bias_i(bias_i), .ofm_o(ofm_o),
    .ofm_valid_o(ofm_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] lane(input int i);
    return 32'($signed(ofm_o[i*WIDTH +: WIDTH]));
  endfunction

  task automatic set_all(input int pix, input int k0, input int k1, input int b);
    ifm_i = WIDTH'(pix);
    for (int i = 0; i < DSP_NO; i++) begin
      k_l0[i] = WIDTH'(k0);
      k_l1[i] = WIDTH'(k1);
      b_v[i]  = ACC_WIDTH'(b);
    end
  endtask

  task automatic do_start(input logic sel);
    @(negedge clk);
    start_i     = 1'b1;
    layer_sel_i = sel;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 1);
  endtask

  // Streams one full run starting at the current negedge, checking address,
  // lane values, strobe timing and done timing until done_o is seen.
  task automatic stream(input string tag, input bit stall, input int pulse_at,
                        input int e0, input int e1, input int e2, input int e3);
    int acc_n = 0, strobes = 0, last_s = -1;
    int exp_t[$];
    int ev[4];
    bit done_seen = 1'b0;
    ev = '{e0, e1, e2, e3};
    for (int k = 0; k < 400 && !done_seen; k++) begin
      chk({tag, "_waddr"}, 32'(weight_addr_o), acc_n % TAPS);
      if (ofm_valid_o) begin
        for (int i = 0; i < DSP_NO; i++)
          chk($sformatf("%s_lane%0d_px%0d", tag, i, strobes), lane(i), ev[i]);
        if (exp_t.size() > 0) chk({tag, "_strobe_time"}, k, exp_t.pop_front());
        else                  chk({tag, "_strobe_unexpected"}, k, -1);
        if (!stall && last_s >= 0) chk({tag, "_strobe_spacing"}, k - last_s, TAPS);
        last_s = k;
        strobes++;
      end else if (strobes > 0) begin
        chk({tag, "_ofm_hold"}, lane(0), ev[0]);
      end
      if (done_o) begin
        done_seen = 1'b1;
        chk({tag, "_done_time"}, k, last_s + 1);
        chk({tag, "_busy_at_done"}, 32'(busy_o), 0);
        chk({tag, "_strobe_count"}, strobes, NPIX);
      end else begin
        ifm_valid_i = (acc_n < NPIX * TAPS) && (!stall || (k % 2 == 0));
        start_i     = (k == pulse_at);
        if (k == pulse_at) layer_sel_i = 1'b1;
        if (ifm_valid_i) begin
          if (acc_n % TAPS == TAPS - 1) exp_t.push_back(k + 2);
          acc_n++;
        end
        @(negedge clk);
      end
    end
    ifm_valid_i = 1'b0;
    start_i     = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_seen), 1);
  endtask

  initial begin
    set_all(0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ofm_any", 32'(|ofm_o), 0);
    chk("rst_ofm_valid", 32'(ofm_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_waddr", 32'(weight_addr_o), 0);
    chk("rst_layer", 32'(layer_o), 0);
    rst = 1'b0;

    // Scenario 1: 0.25 * 0.25 * 18 taps = 1.125 -> 18432
    set_all(4096, 4096, 2048, 0);
    do_start(1'b0);
    stream("base", 1'b0, -1, 18432, 18432, 18432, 18432);

    // Scenario 2: negative lane clamps to 0, bias 2^26 adds 4096
    k_l0[1] = -16'sd4096;
    b_v[2]  = 32'sd67108864;
    do_start(1'b0);
    stream("bias_relu", 1'b0, -1, 18432, 0, 22528, 18432);

    // Scenario 3: 0.5 * 0.5 * 18 = 4.5 > max -> saturate
    set_all(8192, 8192, 2048, 0);
    do_start(1'b0);
    stream("sat", 1'b0, -1, 32767, 32767, 32767, 32767);

    // Scenario 4: alternating stalls give identical results
    set_all(4096, 4096, 2048, 0);
    do_start(1'b0);
    stream("stall", 1'b1, -1, 18432, 18432, 18432, 18432);

    // Scenario 5: reset mid pixel 2, then layer 1 run (0.25 * 0.125 * 18 -> 9216)
    do_start(1'b0);
    for (int k = 0; k < TAPS + 9; k++) begin
      ifm_valid_i = 1'b1;
      @(negedge clk);
    end
    ifm_valid_i = 1'b0;
    chk("pre_rst_lane0", lane(0), 18432);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ofm_any", 32'(|ofm_o), 0);
    chk("midrst_ofm_valid", 32'(ofm_valid_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_done", 32'(done_o), 0);
    chk("midrst_waddr", 32'(weight_addr_o), 0);
    chk("midrst_layer", 32'(layer_o), 0);
    do_start(1'b1);
    chk("layer1_latched", 32'(layer_o), 1);
    stream("layer1", 1'b0, -1, 9216, 9216, 9216, 9216);

    // Scenario 6: start while busy is ignored; start right after done is accepted
    do_start(1'b0);
    stream("busy_start", 1'b0, 20, 18432, 18432, 18432, 18432);
    chk("busy_start_layer", 32'(layer_o), 0);
    do_start(1'b0);
    stream("restart", 1'b0, -1, 18432, 18432, 18432, 18432);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
